// File: rtl/tone_pkg.sv
// Shared tone definitions for the victory melody generator and decoder.
// Note codes, nominal periods at 100 MHz, decision thresholds, melody ROM.
package tone_pkg;

  localparam int PERIOD_W = 20;

  typedef enum logic [2:0] {
    NOTE_C4, NOTE_D4, NOTE_E4, NOTE_F4,
    NOTE_G4, NOTE_A4, NOTE_B4, NOTE_C5
  } note_e;

  typedef enum logic [2:0] {
    M0, M1, M2, M3, M4, M5
  } mstate_e;

  localparam int unsigned NOMINAL [8] = '{
    381678, 340136, 303030, 286532,
    255102, 227272, 202428, 191204
  };

  localparam int unsigned MIDPOINT [7] = '{
    (NOMINAL[0] + NOMINAL[1]) / 2,
    (NOMINAL[1] + NOMINAL[2]) / 2,
    (NOMINAL[2] + NOMINAL[3]) / 2,
    (NOMINAL[3] + NOMINAL[4]) / 2,
    (NOMINAL[4] + NOMINAL[5]) / 2,
    (NOMINAL[5] + NOMINAL[6]) / 2,
    (NOMINAL[6] + NOMINAL[7]) / 2
  };

  localparam int unsigned PERIOD_MIN = 175000;
  localparam int unsigned PERIOD_MAX = 420000;

  function automatic logic in_range(input logic [31:0] p);
    return (p >= PERIOD_MIN) && (p <= PERIOD_MAX);
  endfunction

  // Longer period means lower note: count thresholds at or above p.
  function automatic logic [2:0] classify(input logic [31:0] p);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 7; i++)
      if (p <= MIDPOINT[i]) c = c + 3'd1;
    return c;
  endfunction

  function automatic note_e melody_note(input logic [2:0] idx);
    case (idx)
      3'd0:    return NOTE_C4;
      3'd1:    return NOTE_E4;
      3'd2:    return NOTE_G4;
      3'd3:    return NOTE_C5;
      3'd4:    return NOTE_E4;
      default: return NOTE_C4;
    endcase
  endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Synchronises beep_in, measures rise-to-rise period and detects silence.
// First rise after reset or silence only arms the measurement.
module tone_period_meter
  import tone_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                beep_in,
  output logic                period_valid,
  output logic [PERIOD_W-1:0] period,
  output logic                silent
);

  localparam logic [PERIOD_W-1:0] TMO = PERIOD_W'(TIMEOUT_CYCLES);

  logic                s1, s2, s3;
  logic                rise;
  logic                armed;
  logic [PERIOD_W-1:0] cnt;

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= beep_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A rise in the same cycle as the timeout wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      armed        <= 1'b0;
      silent       <= 1'b1;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (rise) begin
        cnt    <= '0;
        armed  <= 1'b1;
        silent <= 1'b0;
        if (armed) begin
          period       <= cnt + 1'b1;
          period_valid <= 1'b1;
        end
      end else if (cnt != TMO) begin
        cnt <= cnt + 1'b1;
        if (cnt + 1'b1 == TMO) begin
          silent <= 1'b1;
          armed  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/victory_tone_decoder.sv
// Classifies measured tone periods into C-major notes, filters them for
// stability and spots the C4-E4-G4-C5-E4-C4 victory melody.
module victory_tone_decoder
  import tone_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned STABLE_COUNT   = 2,
  parameter int unsigned SCALE_SHIFT    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                beep_in,
  output logic [2:0]          note,
  output logic                note_valid,
  output logic                note_strobe,
  output logic [PERIOD_W-1:0] period,
  output logic                silent,
  output logic                melody_match
);

  localparam logic [2:0] STAB = 3'(STABLE_COUNT);

  logic        period_valid;
  logic [31:0] scaled;
  logic        cls_valid, cls_ok;
  logic [2:0]  cls_code, last_cls;
  logic [2:0]  stab, stab_next;
  logic        nv_q, oor_q;
  mstate_e     m_state, m_next;
  logic        match_d;

  tone_period_meter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_meter (
    .clk         (clk),
    .rst_n       (rst_n),
    .beep_in     (beep_in),
    .period_valid(period_valid),
    .period      (period),
    .silent      (silent)
  );

  // Lets a scaled-down tone map onto the nominal 100 MHz table.
  assign scaled     = 32'(period) << SCALE_SHIFT;
  assign note_valid = nv_q & ~silent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_valid <= 1'b0;
      cls_ok    <= 1'b0;
      cls_code  <= '0;
    end else begin
      cls_valid <= period_valid;
      cls_ok    <= in_range(scaled);
      cls_code  <= classify(scaled);
    end
  end

  always_comb begin
    stab_next = 3'd1;
    if (stab != 3'd0 && cls_code == last_cls)
      stab_next = (stab >= STAB) ? STAB : stab + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab        <= '0;
      last_cls    <= '0;
      note        <= '0;
      nv_q        <= 1'b0;
      note_strobe <= 1'b0;
      oor_q       <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      oor_q       <= 1'b0;
      if (silent) begin
        stab <= '0;
        nv_q <= 1'b0;
      end else if (cls_valid) begin
        if (!cls_ok) begin
          stab  <= '0;
          nv_q  <= 1'b0;
          oor_q <= 1'b1;
        end else begin
          stab     <= stab_next;
          last_cls <= cls_code;
          if (stab_next == STAB && (!nv_q || cls_code != note)) begin
            note        <= cls_code;
            nv_q        <= 1'b1;
            note_strobe <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state      <= M0;
      melody_match <= 1'b0;
    end else begin
      m_state      <= m_next;
      melody_match <= match_d;
    end
  end

  always_comb begin
    m_next  = m_state;
    match_d = 1'b0;
    if (silent || oor_q) begin
      m_next = M0;
    end else if (note_strobe) begin
      if (note == melody_note(m_state)) begin
        if (m_state == M5) begin
          m_next  = M0;
          match_d = 1'b1;
        end else begin
          m_next = mstate_e'(m_state + 3'd1);
        end
      end else begin
        m_next = (note == NOTE_C4) ? M1 : M0;
      end
    end
  end

endmodule

// File: doc/victory_tone_decoder.md
# victory_tone_decoder

Receive-side counterpart of the victory melody generator. Measures the period of a square-wave tone on `beep_in` and classifies it as one of the eight C-major notes C4–C5. Reports note changes and flags the complete victory melody (C4-E4-G4-C5-E4-C4). Used for self-test and loopback checking of the buzzer path in the Pushbox top level; runs at 100 MHz.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: cycles without a rising edge before the input is declared silent (10 ms).
- `STABLE_COUNT`, default 2, range 1–7: consecutive identically classified periods required before a note is reported.
- `clk`  in  1  system clock, 100 MHz
- `rst_n`  in  1  reset, asynchronous, active-low; clock `clk`.
- `beep_in`  in  1  tone input; asynchronous to `clk`.
- `note`  out  3  note code: 0=C4, 1=D4, 2=E4, 3=F4, 4=G4, 5=A4, 6=B4, 7=C5
- `note_valid`  out  1  `note` holds a stable, in-range note
- `note_strobe`  out  1  one-cycle pulse when a stable note is newly reported
- `period`  out  20  last measured full period, in clk cycles
- `silent`  out  1  no rising edge within `TIMEOUT_CYCLES`
- `melody_match`  out  1  one-cycle pulse when the full victory melody has been decoded

## Operation
- **Input conditioning:** `beep_in` passes through a 2-flop synchronizer plus one delay flop. A rising edge is detected as `s2 & ~s3`.
- **Period measurement:** counter `cnt` (20 bits) clears on each rising edge and otherwise increments. It saturates at `TIMEOUT_CYCLES`.
  - On a rising edge, `period <= cnt + 1`, i.e. the exact number of cycles between consecutive rises.
  - Example: the generator's C4 (half-period 190839) measures 381678.
- **Arming:** the first rising edge after reset or after silence only arms the measurement. No period is latched and no classification is made.
- **Silence:** when `cnt` reaches `TIMEOUT_CYCLES`:
  - `silent` goes to 1 and `note_valid` goes to 0.
  - The stability count and the melody index clear.
  - The next rising edge re-arms and drops `silent` to 0.
- **Classification:** nearest nominal note, using midpoint thresholds.
  - Nominal periods: C4 381678, D4 340136, E4 303030, F4 286532, G4 255102, A4 227272, B4 202428, C5 191204.
  - Midpoints: 360907, 321583, 294781, 270817, 241187, 214850, 196816.
  - Periods above 420000 or below 175000 are out of range.
- **Stability filter:** a 3-bit count tracks consecutive matching classifications.
  - An out-of-range period forces `note_valid` to 0 and clears the count.
  - When the count reaches `STABLE_COUNT`:
    - If `note_valid` is 0, or the class differs from `note`: load `note`, set `note_valid`, pulse `note_strobe`.
    - Otherwise no strobe.
  - A single mixed period at a note boundary therefore never produces a strobe when `STABLE_COUNT` ≥ 2.
- **Melody FSM:** states `M0`..`M5` hold the index of the expected note; sequence C4, E4, G4, C5, E4, C4.
  - On `note_strobe` with the expected note: advance. From `M5`, pulse `melody_match` and return to `M0`.
  - On `note_strobe` with the wrong note: go to `M1` if the note is C4, else `M0`.
  - Silence or an out-of-range period returns to `M0`.

## Timing
- **Reset values:** `note` = 0, `note_valid` = 0, `note_strobe` = 0, `period` = 0, `silent` = 1, `melody_match` = 0. The melody FSM is in `M0` and the counters are 0.
- **Latency:** take clk edge k as the first edge sampling `beep_in` high.
  - Edge k+2: `period` updates.
  - Edge k+3: classification registers.
  - Edge k+4: `note`/`note_valid`/`note_strobe` update.
  - Edge k+5: `melody_match`.
- **Silence assertion:** `silent` asserts on the cycle `cnt` reaches `TIMEOUT_CYCLES`. `note_valid` falls on the same edge.
- **Simultaneous rising edge and timeout:** the edge wins. `cnt` clears and no silence is declared.
- **Reset mid-operation:** all state is cleared immediately. The first edge after reset only arms.
- **No gaps required:** there is no handshake. Outputs are level/pulse only, and back-to-back notes with no gap between them are decoded correctly.

## Structure
- **Package `tone_pkg`:** note codes, the nominal period table, midpoint thresholds, `PERIOD_MIN`/`PERIOD_MAX`, and the melody ROM (6 × 3-bit). The generator shares this package.
- **Sub-module `tone_period_meter`:** synchronizer, edge detect, saturating counter, timeout, and the arm flag. It outputs a `period_valid` pulse, `period`, and `silent`.
- **Top module:** classification, stability filter, and melody FSM.

## Test plan
- **Single note:** C4 square wave (half-period 190839) → `period` = 381678; after 2 full periods `note` = 0 with `note_valid` = 1, and exactly one `note_strobe`.
- **Full melody:** 6 notes of 25_000_000 cycles each, no gaps → strobes report notes 0, 2, 4, 7, 2, 0; one `melody_match` pulse 1 cycle after the last strobe; then `silent` = 1 after 1_000_000 idle cycles.
- **Out of range:** half-period 50000 (period 100000) → `note_valid` stays 0, no strobe, `period` = 100000.
- **Wrong sequence:** C4, E4, A4, C4, E4, G4, C5, E4, C4 → no match until the final C4, then exactly one `melody_match`.
- **Glitch period:** one glitch period of 230000 inside a steady G4 → no strobe, and `note` stays 4.
- **Reset mid-melody:** assert `rst_n` during G4 → all outputs return to reset values; the following G4, C5, E4, C4 produce no `melody_match`.
